pow_stream: RTL and testbench

Parametrised AXI-Stream integer power unit: each input beat carries a base and a per-beat exponent, and the block returns base^exponent modulo 2^DATA_W. Throughput is one beat per cycle. Each pipeline stage stalls independently, so bubbles are squeezed out under backpressure. The block sits between stream producers and consumers in the datapath, passing TID/TLAST through unchanged and in order.

---
 rtl/pow_stream_if.sv | 29 ++
 rtl/pow_stream.sv | 121 ++++++++++++
 tb/tb_pow_stream.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pow_stream_if.sv
// rtl/pow_stream_if.sv - stream bundle for pow_stream: s_* beats in, m_* results out
interface pow_stream_if #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 3,
  parameter int ID_W   = 1
);
  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] s_tdata;
  logic [EXP_W-1:0]  s_texp;
  logic [ID_W-1:0]   s_tid;
  logic              s_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic [ID_W-1:0]   m_tid;
  logic              m_tlast;
  logic              m_tovf;

  // master: producer/consumer environment; slave: the power unit
  modport master (
    output s_tvalid, s_tdata, s_texp, s_tid, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tid, m_tlast, m_tovf
  );
  modport slave (
    input  s_tvalid, s_tdata, s_texp, s_tid, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tid, m_tlast, m_tovf
  );
endinterface

// File: rtl/pow_stream.sv
// rtl/pow_stream.sv - pipelined base^exp mod 2^DATA_W stream unit, elastic per-stage stalls
// Optional overflow tracking: define POW_STREAM_OVF_EN.
module pow_stream #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 3,
  parameter int ID_W   = 1
) (
  input logic         clk,
  input logic         aresetn,
  pow_stream_if.slave io
);
  localparam int N = (1 << EXP_W) - 1;

  logic              r_v    [N];
  logic [DATA_W-1:0] r_acc  [N];
  logic [DATA_W-1:0] r_base [N];
  logic [EXP_W-1:0]  r_exp  [N];
  logic [ID_W-1:0]   r_id   [N];
  logic              r_last [N];
  logic [N-1:0]      w_en;
  logic [DATA_W-1:0] w_acc_nxt [N];
`ifdef POW_STREAM_OVF_EN
  logic              r_ovf     [N];
  logic              w_ovf_nxt [N];
  logic [2*DATA_W-1:0] w_prod;
`else
  logic [DATA_W-1:0] w_prod;
`endif

  // A stage may advance when it is empty or its successor advances too.
  always_comb begin
    w_en = '0;
    w_en[N-1] = ~r_v[N-1] | io.m_tready;
    for (int k = N - 2; k >= 0; k--) begin
      w_en[k] = ~r_v[k] | w_en[k+1];
    end
  end

  always_comb begin
    w_prod = '0;
    for (int k = 0; k < N; k++) begin
      w_acc_nxt[k] = '0;
`ifdef POW_STREAM_OVF_EN
      w_ovf_nxt[k] = 1'b0;
`endif
    end
    w_acc_nxt[0] = (io.s_texp != '0) ? io.s_tdata : DATA_W'(1);
    for (int k = 1; k < N; k++) begin
`ifdef POW_STREAM_OVF_EN
      w_prod = {{DATA_W{1'b0}}, r_acc[k-1]} * {{DATA_W{1'b0}}, r_base[k-1]};
`else
      w_prod = r_acc[k-1] * r_base[k-1];
`endif
      // Stage k contributes the (k+1)-th factor only when the exponent reaches it.
      if (r_exp[k-1] >= EXP_W'(k + 1)) begin
        w_acc_nxt[k] = w_prod[DATA_W-1:0];
`ifdef POW_STREAM_OVF_EN
        w_ovf_nxt[k] = r_ovf[k-1] | (|w_prod[2*DATA_W-1:DATA_W]);
`endif
      end else begin
        w_acc_nxt[k] = r_acc[k-1];
`ifdef POW_STREAM_OVF_EN
        w_ovf_nxt[k] = r_ovf[k-1];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < N; k++) begin
        r_v[k]    <= 1'b0;
        r_acc[k]  <= '0;
        r_base[k] <= '0;
        r_exp[k]  <= '0;
        r_id[k]   <= '0;
        r_last[k] <= 1'b0;
`ifdef POW_STREAM_OVF_EN
        r_ovf[k]  <= 1'b0;
`endif
      end
    end else begin
      if (w_en[0]) begin
        r_v[0]    <= io.s_tvalid;
        r_acc[0]  <= w_acc_nxt[0];
        r_base[0] <= io.s_tdata;
        r_exp[0]  <= io.s_texp;
        r_id[0]   <= io.s_tid;
        r_last[0] <= io.s_tlast;
`ifdef POW_STREAM_OVF_EN
        r_ovf[0]  <= 1'b0;
`endif
      end
      for (int k = 1; k < N; k++) begin
        if (w_en[k]) begin
          r_v[k]    <= r_v[k-1];
          r_acc[k]  <= w_acc_nxt[k];
          r_base[k] <= r_base[k-1];
          r_exp[k]  <= r_exp[k-1];
          r_id[k]   <= r_id[k-1];
          r_last[k] <= r_last[k-1];
`ifdef POW_STREAM_OVF_EN
          r_ovf[k]  <= w_ovf_nxt[k];
`endif
        end
      end
    end
  end

  assign io.s_tready = aresetn & w_en[0];
  assign io.m_tvalid = r_v[N-1];
  assign io.m_tdata  = r_acc[N-1];
  assign io.m_tid    = r_id[N-1];
  assign io.m_tlast  = r_last[N-1];
`ifdef POW_STREAM_OVF_EN
  assign io.m_tovf   = r_ovf[N-1];
`else
  assign io.m_tovf   = 1'b0;
`endif

endmodule

// File: tb/tb_pow_stream.sv
// tb/tb_pow_stream.sv - scoreboard bench for pow_stream with directed vectors
module tb_pow_stream;
  localparam int DW = 32;
  localparam int EW = 3;
  localparam int IW = 1;
`ifdef POW_STREAM_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        id;
    logic        last;
    logic        ovf;
  } beat_t;

  logic  clk = 1'b0;
  logic  aresetn = 1'b0;
  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    n_acc = 0;
  int    drop_at = -1;

  always #5 clk = ~clk;

  pow_stream_if #(.DATA_W(DW), .EXP_W(EW), .ID_W(IW)) bus();

  pow_stream #(.DATA_W(DW), .EXP_W(EW), .ID_W(IW)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .io      (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t model(input logic [31:0] b, input logic [2:0] e,
                                  input logic id, input logic last);
    beat_t       x;
    logic [63:0] p;
    x.d = (e >= 3'd1) ? b : 32'd1;
    x.ovf = 1'b0;
    for (int k = 2; k <= int'(e); k++) begin
      p = {32'd0, x.d} * {32'd0, b};
      if (p[63:32] != 32'd0) x.ovf = 1'b1;
      x.d = p[31:0];
    end
    x.id = id;
    x.last = last;
    if (!OVF_ON) x.ovf = 1'b0;
    return x;
  endfunction

  task automatic send(input logic [31:0] b, input logic [2:0] e, input logic id,
                      input logic last, input beat_t want);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = b;
    bus.s_texp   = e;
    bus.s_tid    = id;
    bus.s_tlast  = last;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (bus.s_tready) begin
        acc = 1'b1;
        exp_q.push_back(want);
        n_acc++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.s_tvalid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept want accept (base 0x%0h)", b);
    end
  endtask

  task automatic send_d(input logic [31:0] b, input logic [2:0] e, input logic id,
                        input logic last, input logic [31:0] d, input logic ovf);
    beat_t w;
    w.d = d;
    w.id = id;
    w.last = last;
    w.ovf = OVF_ON ? ovf : 1'b0;
    send(b, e, id, last, w);
  endtask

  task automatic send_m(input logic [31:0] b, input logic [2:0] e, input logic id,
                        input logic last);
    send(b, e, id, last, model(b, e, id, last));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      cyc();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: a beat transfers on the next edge when valid and ready at the negedge.
  initial begin
    beat_t got;
    beat_t want;
    forever begin
      @(negedge clk);
      if (aresetn && bus.m_tvalid && bus.m_tready) begin
        got = {bus.m_tdata, bus.m_tid, bus.m_tlast, bus.m_tovf};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got 0x%0h want none", got);
        end else begin
          want = exp_q.pop_front();
          chk("result", 64'(got), 64'(want));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.s_texp   = '0;
    bus.s_tid    = '0;
    bus.s_tlast  = 1'b0;
    bus.m_tready = 1'b1;
    #2;
    chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("rst_m_tdata",  64'(bus.m_tdata),  64'd0);
    chk("rst_m_side",   64'({bus.m_tid, bus.m_tlast, bus.m_tovf}), 64'd0);
    chk("rst_s_tready", 64'(bus.s_tready), 64'd0);
    cyc();
    cyc();
    aresetn = 1'b1;
    #1;
    chk("post_rst_s_tready", 64'(bus.s_tready), 64'd1);
    cyc();

    // latency: accepted on edge T, valid after edge T+6
    send_d(32'd3, 3'd4, 1'b0, 1'b0, 32'd81, 1'b0);
    repeat (5) cyc();
    chk("latency_early", 64'(bus.m_tvalid), 64'd0);
    cyc();
    chk("latency_on_time", 64'(bus.m_tvalid), 64'd1);
    send_d(32'd2,          3'd7, 1'b1, 1'b0, 32'd128, 1'b0);
    send_d(32'd0,          3'd0, 1'b0, 1'b1, 32'd1,   1'b0);
    send_d(32'hFFFF_FFFF,  3'd0, 1'b1, 1'b0, 32'd1,   1'b0);
    send_d(32'h0001_0000,  3'd2, 1'b0, 1'b0, 32'd0,   1'b1);
    send_d(32'hFFFF_FFFF,  3'd2, 1'b1, 1'b1, 32'd1,   1'b1);
    drain();

    // backpressure
    bus.m_tready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send_m(32'(i), 3'(i % 8), 1'(i % 2), (i % 4) == 3);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (!bus.s_tready && drop_at < 0) drop_at = n_acc;
          @(posedge clk);
          #1;
        end
        bus.m_tready = 1'b1;
        #1;
        chk("bp_ready_comb", 64'(bus.s_tready), 64'd1);
      end
    join
    chk("bp_full_count", 64'(drop_at), 64'd7);
    drain();

    // bubble squeeze
    bus.m_tready = 1'b0;
    send_d(32'd2, 3'd3, 1'b1, 1'b0, 32'd8, 1'b0);
    repeat (3) cyc();
    send_d(32'd3, 3'd2, 1'b0, 1'b1, 32'd9, 1'b0);
    repeat (10) cyc();
    chk("bubble_adjacent", 64'({dut.r_v[6], dut.r_v[5], dut.r_v[4]}), 64'b110);
    chk("bubble_s_tready", 64'(bus.s_tready), 64'd1);
    for (int i = 0; i < 5; i++) send_m(32'(10 + i), 3'd1, 1'(i % 2), 1'b0);
    chk("bubble_full", 64'(bus.s_tready), 64'd0);
    bus.m_tready = 1'b1;
    drain();

    // reset mid-flight
    bus.m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send_m(32'(i + 1), 3'd2, 1'b1, 1'b1);
    repeat (8) cyc();
    chk("mid_valid_before", 64'(bus.m_tvalid), 64'd1);
    #3;
    aresetn = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("mid_rst_m_data",   64'({bus.m_tdata, bus.m_tid, bus.m_tlast, bus.m_tovf}), 64'd0);
    chk("mid_rst_s_tready", 64'(bus.s_tready), 64'd0);
    cyc();
    cyc();
    aresetn = 1'b1;
    bus.m_tready = 1'b1;
    repeat (15) cyc();
    chk("no_stale", 64'(bus.m_tvalid), 64'd0);
    send_d(32'd5, 3'd3, 1'b1, 1'b1, 32'd125, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
